// File: rtl/cla_addsub_seq_if.sv
// Operand/handshake/result bundle for cla_addsub_seq.
// The master side presents operands and control; the slave side is the adder.
interface cla_addsub_seq_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             addsub;
    logic             load;
    logic             submit;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] R;
    logic [3:0]       flags_znvc;

    modport master (
        output a_in, b_in, addsub, load, submit,
        input  busy, done, R, flags_znvc
    );

    modport slave (
        input  a_in, b_in, addsub, load, submit,
        output busy, done, R, flags_znvc
    );
endinterface

// File: rtl/cla_addsub_seq.sv
// Multi-cycle carry-lookahead adder/subtractor.
// One BLOCK-bit lookahead group is evaluated per cycle; the group carry-out is
// registered and becomes the next group's carry-in, so an operation takes
// WIDTH/BLOCK cycles. WIDTH must be a multiple of BLOCK.
// Subtraction is A + ~B + 1: the initial carry-in is the add/sub mode bit.
module cla_addsub_seq #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             reset,
    cla_addsub_seq_if.slave  bus
);
    localparam int NG = WIDTH / BLOCK;
    localparam int KW = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] r_q;
    logic [3:0]       flags_q;
    logic             busy_q;
    logic             done_q;

    int               grp_base_s;
    logic [BLOCK-1:0] a_grp_s;
    logic [BLOCK-1:0] b_grp_s;
    logic [BLOCK-1:0] g_s;
    logic [BLOCK-1:0] p_s;
    logic [BLOCK:0]   c_s;
    logic [BLOCK-1:0] grp_sum_s;
    logic [WIDTH-1:0] sum_d;
    logic [3:0]       flags_d;
    logic             last_s;

    // Select the current group's operand slice and form generate/propagate.
    always_comb begin
        grp_base_s = int'(k_q) * BLOCK;
        a_grp_s    = a_q[grp_base_s +: BLOCK];
        if (sub_q) begin
            b_grp_s = ~b_q[grp_base_s +: BLOCK];
        end else begin
            b_grp_s = b_q[grp_base_s +: BLOCK];
        end
        g_s = a_grp_s & b_grp_s;
        p_s = a_grp_s ^ b_grp_s;
    end

    // Flattened lookahead: each carry is a sum of products of g/p and the
    // registered carry-in, never built from the previous bit's carry.
    always_comb begin
        logic acc;
        logic term;
        acc    = 1'b0;
        term   = 1'b0;
        c_s    = '0;
        c_s[0] = carry_q;
        for (int i = 0; i < BLOCK; i++) begin
            acc = carry_q;
            for (int j = 0; j <= i; j++) begin
                acc = acc & p_s[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = g_s[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p_s[m];
                end
                acc = acc | term;
            end
            c_s[i+1] = acc;
        end
    end

    // Merge this group's sum into the partial result and derive the flags
    // that apply when this is the final (MSB) group.
    always_comb begin
        grp_sum_s = p_s ^ c_s[BLOCK-1:0];
        sum_d     = sum_q;
        sum_d[grp_base_s +: BLOCK] = grp_sum_s;
        flags_d   = {(sum_d == {WIDTH{1'b0}}), sum_d[WIDTH-1],
                     c_s[BLOCK] ^ c_s[BLOCK-1], c_s[BLOCK]};
        last_s    = (k_q == KW'(NG - 1));
    end

    // Control FSM with operand, carry, partial-sum and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            r_q     <= '0;
            flags_q <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        a_q   <= bus.a_in;
                        b_q   <= bus.b_in;
                        sub_q <= bus.addsub;
                    end
                    if (bus.submit) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                        sum_q   <= '0;
                        // A simultaneous load supplies the mode for this op.
                        carry_q <= bus.load ? bus.addsub : sub_q;
                    end
                end
                CALC: begin
                    sum_q   <= sum_d;
                    carry_q <= c_s[BLOCK];
                    if (last_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        k_q     <= '0;
                        r_q     <= sum_d;
                        flags_q <= flags_d;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.R          = r_q;
    assign bus.flags_znvc = flags_q;
endmodule

// File: tb/tb_cla_addsub_seq.sv
// Directed bench for cla_addsub_seq: an 8/4 instance and a 16/4 instance.
module tb_cla_addsub_seq;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;

    cla_addsub_seq_if #(.WIDTH(8))  bus8  ();
    cla_addsub_seq_if #(.WIDTH(16)) bus16 ();

    cla_addsub_seq #(.WIDTH(8),  .BLOCK(4)) dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
    cla_addsub_seq #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done on the 8-bit instance; we are at #1 after the submit edge.
    task automatic wait_done8(input string tag, input int exp_lat);
        step();
        chk({tag, "_busy1"}, 32'(bus8.busy), 32'd1);
        chk({tag, "_done0"}, 32'(bus8.done), 32'd0);
        cyc = 1;
        while (!bus8.done && cyc < 12) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_busy_at_done"}, 32'(bus8.busy), 32'd0);
    endtask

    // Present operands (optionally with load) plus submit for one cycle, then
    // check latency, result and flags.
    task automatic op8(input string tag, input bit do_load, input logic [7:0] a,
                       input logic [7:0] b, input logic s,
                       input logic [7:0] exp_r, input logic [3:0] exp_f);
        bus8.a_in   = a;
        bus8.b_in   = b;
        bus8.addsub = s;
        bus8.load   = do_load;
        bus8.submit = 1'b1;
        step();
        bus8.load   = 1'b0;
        bus8.submit = 1'b0;
        wait_done8(tag, 2);
        chk({tag, "_R"},    32'(bus8.R),          32'(exp_r));
        chk({tag, "_znvc"}, 32'(bus8.flags_znvc), 32'(exp_f));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus8.a_in = 8'h00;   bus8.b_in = 8'h00;   bus8.addsub = 1'b0;
        bus8.load = 1'b0;    bus8.submit = 1'b0;
        bus16.a_in = 16'h0000; bus16.b_in = 16'h0000; bus16.addsub = 1'b0;
        bus16.load = 1'b0;   bus16.submit = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_busy", 32'(bus8.busy),       32'd0);
        chk("rst_done", 32'(bus8.done),       32'd0);
        chk("rst_R",    32'(bus8.R),          32'd0);
        chk("rst_znvc", 32'(bus8.flags_znvc), 32'd0);

        // Signed overflow into the sign bit
        op8("t1", 1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0110);
        step();
        chk("t1_done_pulse", 32'(bus8.done), 32'd0);
        chk("t1_R_hold",     32'(bus8.R),    32'h80);

        // Carry out to zero; equal subtract (no borrow)
        op8("t2a", 1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1001);
        op8("t2b", 1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1001);

        // Borrow, then back-to-back submit in the done cycle
        op8("t3a", 1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b0100);
        op8("t3b", 1'b1, 8'h10, 8'h20, 1'b0, 8'h30, 4'b0000);

        // load/submit while busy are ignored
        step();
        bus8.a_in = 8'h30; bus8.b_in = 8'h05; bus8.addsub = 1'b0;
        bus8.load = 1'b1;  bus8.submit = 1'b1;
        step();
        bus8.a_in = 8'h11; bus8.b_in = 8'h77; bus8.addsub = 1'b1;
        step();
        chk("t4_busy", 32'(bus8.busy), 32'd1);
        bus8.load = 1'b0;  bus8.submit = 1'b0;
        step();
        chk("t4_done", 32'(bus8.done),       32'd1);
        chk("t4_R",    32'(bus8.R),          32'h35);
        chk("t4_znvc", 32'(bus8.flags_znvc), 32'h0);
        step();
        chk("t4_no_second_op", 32'(bus8.busy), 32'd0);
        op8("t4_resub", 1'b0, 8'hEE, 8'hEE, 1'b1, 8'h35, 4'b0000);

        // Reset mid-operation aborts it
        step();
        bus8.a_in = 8'h12; bus8.b_in = 8'h34; bus8.addsub = 1'b0;
        bus8.load = 1'b1;  bus8.submit = 1'b1;
        step();
        bus8.load = 1'b0;  bus8.submit = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_busy", 32'(bus8.busy),       32'd0);
        chk("t5_R",    32'(bus8.R),          32'd0);
        chk("t5_znvc", 32'(bus8.flags_znvc), 32'd0);
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus8.done) cyc++;
        end
        chk("t5_no_done", 32'(cyc), 32'd0);
        // Operand regs were cleared: 0 + 0
        op8("t5_cleared", 1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 4'b1000);
        op8("t5_after",   1'b1, 8'h01, 8'h02, 1'b0, 8'h03, 4'b0000);

        // 16-bit, four groups
        step();
        bus16.a_in = 16'h8000; bus16.b_in = 16'h0001; bus16.addsub = 1'b1;
        bus16.load = 1'b1;     bus16.submit = 1'b1;
        step();
        bus16.load = 1'b0;     bus16.submit = 1'b0;
        cyc = 0;
        while (!bus16.done && cyc < 12) begin
            step();
            cyc++;
            if (cyc == 3) chk("t6_busy", 32'(bus16.busy), 32'd1);
        end
        chk("t6_lat",  32'(cyc),               32'd4);
        chk("t6_R",    32'(bus16.R),           32'h7FFF);
        chk("t6_znvc", 32'(bus16.flags_znvc),  32'b0011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
